// File: rtl/hero_bus_rx.sv
// Hero write bus receiver: frames incoming beats into messages, buffers them in a
// FIFO and streams them out with a last marker, enforcing a maximum message length.
module hero_bus_rx #(
  parameter int unsigned HERO_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_BEATS  = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            in_cycle,
  input  logic [HERO_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [HERO_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  err_trunc,
  output logic                  err_illegal,
  output logic [CNT_W-1:0]      msg_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW = $clog2(MAX_BEATS + 1);

  localparam logic [1:0] CYC_VALID   = 2'd1;
  localparam logic [1:0] CYC_DONE    = 2'd2;
  localparam logic [1:0] CYC_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

  state_t                state, state_nxt;
  logic [BW-1:0]         beat_cnt;
  logic [HERO_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]      last_mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;

  logic fifo_full_c, acc_valid_c, acc_done_c, at_max_c, pop_c;
  logic push_c, push_last_c, msg_inc_c, trunc_c;

  assign fifo_full_c = (count == (AW+1)'(DEPTH));
  assign in_ready    = !fifo_full_c || (state == S_DROP);
  assign acc_valid_c = in_ready && (in_cycle == CYC_VALID);
  assign acc_done_c  = in_ready && (in_cycle == CYC_DONE);
  assign at_max_c    = (BW'(beat_cnt + BW'(1)) == BW'(MAX_BEATS));

  // FIFO head is read straight out of the storage registers
  assign out_valid = (count != '0);
  assign out_data  = data_mem[rd_ptr];
  assign out_last  = last_mem[rd_ptr];
  assign pop_c     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RECV: begin
        if (acc_valid_c)     state_nxt = at_max_c ? S_DROP : S_RECV;
        else if (acc_done_c) state_nxt = S_IDLE;
      end
      S_DROP:  if (acc_done_c) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    push_c      = 1'b0;
    push_last_c = 1'b0;
    msg_inc_c   = 1'b0;
    trunc_c     = 1'b0;
    if (state != S_DROP) begin
      if (acc_valid_c) begin
        push_c      = 1'b1;
        push_last_c = at_max_c;
        msg_inc_c   = at_max_c;
        trunc_c     = at_max_c;
      end else if (acc_done_c) begin
        push_c      = 1'b1;
        push_last_c = 1'b1;
        msg_inc_c   = 1'b1;
      end
    end
  end

  // Beat counter only carries meaning while a message is being received
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  beat_cnt <= '0;
    else if (state_nxt != S_RECV) beat_cnt <= '0;
    else if (push_c)             beat_cnt <= BW'(beat_cnt + BW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) data_mem[i] <= '0;
      last_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push_c) begin
        data_mem[wr_ptr] <= in_data;
        last_mem[wr_ptr] <= push_last_c;
        wr_ptr           <= AW'(wr_ptr + AW'(1));
      end
      if (pop_c) rd_ptr <= AW'(rd_ptr + AW'(1));
      case ({push_c, pop_c})
        2'b10:   count <= (AW+1)'(count + (AW+1)'(1));
        2'b01:   count <= (AW+1)'(count - (AW+1)'(1));
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_count   <= '0;
      err_trunc   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (msg_inc_c && (msg_count != {CNT_W{1'b1}})) msg_count <= CNT_W'(msg_count + CNT_W'(1));
      err_trunc   <= trunc_c;
      err_illegal <= in_ready && (in_cycle == CYC_ILLEGAL);
    end
  end

endmodule
